wb_port_arbiter: RTL and testbench

//  Shares the single register-file write port between the pipeline write-back stage and the

---
 rtl/wb_defs_pkg.sv | 22 ++
 rtl/wb_pend_fifo.sv | 81 ++++++++
 rtl/wb_port_arbiter.sv | 140 ++++++++++++++
 tb/tb_wb_port_arbiter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_defs_pkg.sv
// Shared definitions for the register-file write-port arbiter.
//   DEF_DATA_W / DEF_ADDR_W : default register data / index widths
//   arb_state_t             : arbiter FSM states
//   pend_entry_t            : one pending MDU result {valid, rd, data}
package wb_defs;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;

    typedef enum logic [1:0] {
        IDLE,
        PEND,
        FORCE
    } arb_state_t;

    typedef struct packed {
        logic                  valid;
        logic [DEF_ADDR_W-1:0] rd;
        logic [DEF_DATA_W-1:0] data;
    } pend_entry_t;

endpackage

// File: rtl/wb_pend_fifo.sv
// Pending-result FIFO for MDU write-backs.
//   clk, rst                  : clock, asynchronous active-low reset
//   push, push_valid          : enqueue strobe and live flag of the incoming entry
//   push_rd, push_data        : incoming entry destination / data
//   pop                       : dequeue the head
//   kill_en, kill_rd          : invalidate every entry (including the one being
//                               pushed) whose rd equals kill_rd
//   head_valid/rd/data        : head entry
//   count, full               : occupancy
module wb_pend_fifo import wb_defs::*; #(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     push_valid,
    input  logic [ADDR_W-1:0]        push_rd,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    input  logic                     kill_en,
    input  logic [ADDR_W-1:0]        kill_rd,
    output logic                     head_valid,
    output logic [ADDR_W-1:0]        head_rd,
    output logic [DATA_W-1:0]        head_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DEPTH-1:0]  ent_valid;
    logic [ADDR_W-1:0] ent_rd   [DEPTH];
    logic [DATA_W-1:0] ent_data [DEPTH];
    logic [PTR_W-1:0]  wptr;
    logic [PTR_W-1:0]  rptr;
    logic [CNT_W-1:0]  cnt;

    // Control: pointers, occupancy, live flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ent_valid <= '0;
            wptr      <= '0;
            rptr      <= '0;
            cnt       <= '0;
        end else begin
            // Killing a free slot is harmless, so the match runs over all slots.
            for (int i = 0; i < DEPTH; i++) begin
                if (kill_en && (ent_rd[i] == kill_rd))
                    ent_valid[i] <= 1'b0;
            end
            if (push) begin
                ent_valid[wptr] <= push_valid && !(kill_en && (push_rd == kill_rd));
                wptr            <= wptr + PTR_W'(1);
            end
            if (pop)
                rptr <= rptr + PTR_W'(1);
            if (push && !pop)
                cnt <= cnt + CNT_W'(1);
            else if (!push && pop)
                cnt <= cnt - CNT_W'(1);
        end
    end

    // Payload storage carries no reset; occupancy alone decides what is meaningful.
    always_ff @(posedge clk) begin
        if (push) begin
            ent_rd[wptr]   <= push_rd;
            ent_data[wptr] <= push_data;
        end
    end

    assign head_valid = ent_valid[rptr];
    assign head_rd    = ent_rd[rptr];
    assign head_data  = ent_data[rptr];
    assign count      = cnt;
    assign full       = (cnt == CNT_W'(DEPTH));

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline write-back has priority, MDU
// results wait in a small FIFO, and a starvation counter forces a one-cycle
// pipeline stall to drain the FIFO head.
//   clk, rst                    : clock, asynchronous active-low reset
//   wb_valid, wb_rd, wb_data    : pipeline write request
//   mdu_valid, mdu_ready        : MDU result handshake (ready = FIFO not full)
//   mdu_rd, mdu_data            : MDU result
//   stall_pipe                  : registered; pipeline holds its request
//   rf_we, rf_rd, rf_wdata      : registered register-file write port
//   pend_cnt                    : FIFO occupancy
module wb_port_arbiter import wb_defs::*; #(
    parameter int DATA_W       = DEF_DATA_W,
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wb_valid,
    input  logic [ADDR_W-1:0]      wb_rd,
    input  logic [DATA_W-1:0]      wb_data,
    input  logic                   mdu_valid,
    output logic                   mdu_ready,
    input  logic [ADDR_W-1:0]      mdu_rd,
    input  logic [DATA_W-1:0]      mdu_data,
    output logic                   stall_pipe,
    output logic                   rf_we,
    output logic [ADDR_W-1:0]      rf_rd,
    output logic [DATA_W-1:0]      rf_wdata,
    output logic [$clog2(DEPTH):0] pend_cnt
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int SC_W  = $clog2(STARVE_LIMIT) + 1;

    arb_state_t        state, next_state;
    logic [SC_W-1:0]   starve, starve_next;
    logic [CNT_W-1:0]  fifo_cnt, cnt_next;
    logic              fifo_full;
    logic              head_valid;
    logic [ADDR_W-1:0] head_rd;
    logic [DATA_W-1:0] head_data;
    logic              push, pop, nonempty;
    logic              pipe_grant, kill_hit, head_live;
    logic              head_grant, head_denied, starve_hit;

    assign mdu_ready = !fifo_full;
    assign push      = mdu_valid && mdu_ready;
    assign pend_cnt  = fifo_cnt;

    // rd==0 entries are stored dead so they pop without a write.
    wb_pend_fifo #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_valid (mdu_rd != '0),
        .push_rd    (mdu_rd),
        .push_data  (mdu_data),
        .pop        (pop),
        .kill_en    (pipe_grant),
        .kill_rd    (wb_rd),
        .head_valid (head_valid),
        .head_rd    (head_rd),
        .head_data  (head_data),
        .count      (fifo_cnt),
        .full       (fifo_full)
    );

    // State register and starve counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            starve <= '0;
        end else begin
            state  <= next_state;
            starve <= starve_next;
        end
    end

    // Grant decisions
    always_comb begin
        nonempty    = (fifo_cnt != '0);
        // A pipeline write to rd 0 is a no-op and does not claim the port.
        pipe_grant  = wb_valid && (wb_rd != '0) && (state != FORCE);
        // A head about to be overwritten by a younger pipeline write is treated as dead now.
        kill_hit    = pipe_grant && (head_rd == wb_rd);
        head_live   = nonempty && head_valid && !kill_hit;
        head_grant  = head_live && !pipe_grant;
        head_denied = head_live && pipe_grant;
        pop         = nonempty && !head_denied;
    end

    // Next state and counter
    always_comb begin
        cnt_next = fifo_cnt;
        if (push && !pop)
            cnt_next = fifo_cnt + CNT_W'(1);
        else if (!push && pop)
            cnt_next = fifo_cnt - CNT_W'(1);

        starve_hit  = head_denied && (starve == SC_W'(STARVE_LIMIT - 1));
        starve_next = starve;
        if (pop)
            starve_next = '0;
        else if (head_denied && !starve_hit)
            starve_next = starve + SC_W'(1);

        if (starve_hit)
            next_state = FORCE;
        else if (cnt_next != '0)
            next_state = PEND;
        else
            next_state = IDLE;
    end

    // Output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rf_we      <= 1'b0;
            rf_rd      <= '0;
            rf_wdata   <= '0;
            stall_pipe <= 1'b0;
        end else begin
            rf_we      <= pipe_grant || head_grant;
            stall_pipe <= (next_state == FORCE);
            if (pipe_grant) begin
                rf_rd    <= wb_rd;
                rf_wdata <= wb_data;
            end else if (head_grant) begin
                rf_rd    <= head_rd;
                rf_wdata <= head_data;
            end
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;
    import wb_defs::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [31:0] wb_data = '0;
    logic        mdu_valid = 1'b0;
    logic        mdu_ready;
    logic [4:0]  mdu_rd = '0;
    logic [31:0] mdu_data = '0;
    logic        stall_pipe;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wdata;
    logic [1:0]  pend_cnt;

    int checks   = 0;
    int failures = 0;
    pend_entry_t exp_q[$];

    wb_port_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .mdu_valid  (mdu_valid),
        .mdu_ready  (mdu_ready),
        .mdu_rd     (mdu_rd),
        .mdu_data   (mdu_data),
        .stall_pipe (stall_pipe),
        .rf_we      (rf_we),
        .rf_rd      (rf_rd),
        .rf_wdata   (rf_wdata),
        .pend_cnt   (pend_cnt)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        wb_valid  = 1'b0; wb_rd  = '0; wb_data  = '0;
        mdu_valid = 1'b0; mdu_rd = '0; mdu_data = '0;
    endtask

    task automatic expect_wr(input logic [4:0] rd, input logic [31:0] d);
        pend_entry_t e;
        e.valid = 1'b1;
        e.rd    = rd;
        e.data  = d;
        exp_q.push_back(e);
    endtask

    task automatic set_wb(input logic [4:0] rd, input logic [31:0] d);
        wb_valid = 1'b1; wb_rd = rd; wb_data = d;
    endtask

    task automatic set_mdu(input logic [4:0] rd, input logic [31:0] d);
        mdu_valid = 1'b1; mdu_rd = rd; mdu_data = d;
    endtask

    // Bounded wait for all expected writes and the FIFO to empty, then a
    // short quiet window so stray writes reach the monitor.
    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || pend_cnt != 0) && n < 20) begin
            tick();
            n++;
        end
        chk({name, "_exp_empty"}, exp_q.size(), 0);
        chk({name, "_pend_zero"}, pend_cnt, 0);
        tick();
        tick();
    endtask

    // Scoreboard monitor: every write the DUT presents is matched in order.
    always @(negedge clk) begin
        if (rst && rf_we) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write actual=rd%0d/0x%0h required=no_write", rf_rd, rf_wdata);
            end else begin
                pend_entry_t e;
                e = exp_q.pop_front();
                chk("write_rd", rf_rd, e.rd);
                chk("write_data", rf_wdata, e.data);
            end
        end
    end

    initial begin
        // Power-on reset
        #2 rst = 1'b0;
        #1;
        chk("por_rf_we", rf_we, 0);
        chk("por_stall", stall_pipe, 0);
        chk("por_pend", pend_cnt, 0);
        chk("por_ready", mdu_ready, 1);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        tick();

        // 1: reset mid-operation with two entries queued during a forced stall
        set_mdu(5'd3, 32'h33);
        tick();
        set_mdu(5'd4, 32'h44);
        set_wb(5'd5, 32'h501); expect_wr(5'd5, 32'h501);
        tick();
        mdu_valid = 1'b0;
        for (int k = 2; k <= 4; k++) begin
            wb_data = 32'h500 + k;
            expect_wr(5'd5, 32'h500 + k);
            tick();
        end
        idle_in();
        @(negedge clk);
        #1;
        chk("t1_stall_on", stall_pipe, 1);
        chk("t1_pend_two", pend_cnt, 2);
        chk("t1_full", mdu_ready, 0);
        rst = 1'b0;
        #1;
        chk("t1_rst_we", rf_we, 0);
        chk("t1_rst_rd", rf_rd, 0);
        chk("t1_rst_wdata", rf_wdata, 0);
        chk("t1_rst_stall", stall_pipe, 0);
        chk("t1_rst_pend", pend_cnt, 0);
        chk("t1_rst_ready", mdu_ready, 1);
        chk("t1_exp_empty", exp_q.size(), 0);
        @(posedge clk);
        #1 rst = 1'b1;
        tick();

        // 2: idle port drains an MDU result
        set_mdu(5'd7, 32'h1234); expect_wr(5'd7, 32'h1234);
        tick();
        idle_in();
        chk("t2_pend_one", pend_cnt, 1);
        tick();
        chk("t2_pend_zero", pend_cnt, 0);
        drain("t2");

        // 3: starvation forces a one-cycle stall after four pipeline writes
        set_mdu(5'd3, 32'h3333);
        tick();
        mdu_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            set_wb(5'd5, 32'h5000 + k);
            expect_wr(5'd5, 32'h5000 + k);
            tick();
            if (k < 4) chk("t3_no_early_stall", stall_pipe, 0);
        end
        chk("t3_stall_on", stall_pipe, 1);
        expect_wr(5'd3, 32'h3333);
        set_wb(5'd5, 32'h5005);
        tick();
        chk("t3_stall_off", stall_pipe, 0);
        expect_wr(5'd5, 32'h5005);
        tick();
        wb_data = 32'h5006; expect_wr(5'd5, 32'h5006);
        tick();
        idle_in();
        drain("t3");

        // 4: same-cycle kill of a pushed entry
        set_mdu(5'd9, 32'hDEAD);
        set_wb(5'd9, 32'hA5A5A5A5); expect_wr(5'd9, 32'hA5A5A5A5);
        tick();
        idle_in();
        chk("t4_pend_accepted", pend_cnt, 1);
        tick();
        chk("t4_no_stall", stall_pipe, 0);
        drain("t4");

        // 4b: kill of an entry already at the head
        set_mdu(5'd20, 32'h2020);
        tick();
        mdu_valid = 1'b0;
        set_wb(5'd20, 32'h77); expect_wr(5'd20, 32'h77);
        tick();
        idle_in();
        chk("t4b_pend_zero", pend_cnt, 0);
        drain("t4b");

        // 5: full FIFO refuses a push, then writes stay in order across the wrap
        set_wb(5'd5, 32'h5100); expect_wr(5'd5, 32'h5100);
        set_mdu(5'd10, 32'hA0);
        tick();
        wb_data = 32'h5101; expect_wr(5'd5, 32'h5101);
        set_mdu(5'd11, 32'hB0);
        tick();
        chk("t5_not_ready", mdu_ready, 0);
        wb_data = 32'h5102; expect_wr(5'd5, 32'h5102);
        set_mdu(5'd12, 32'hC0);
        tick();
        chk("t5_pend_full", pend_cnt, 2);
        idle_in();
        expect_wr(5'd10, 32'hA0);
        expect_wr(5'd11, 32'hB0);
        drain("t5a");
        set_mdu(5'd13, 32'hD0); expect_wr(5'd13, 32'hD0);
        tick();
        chk("t5_pend_one", pend_cnt, 1);
        set_mdu(5'd14, 32'hE0); expect_wr(5'd14, 32'hE0);
        tick();
        chk("t5_push_pop_same", pend_cnt, 1);
        set_mdu(5'd15, 32'hF0); expect_wr(5'd15, 32'hF0);
        tick();
        idle_in();
        drain("t5b");

        // 6: rd 0 never writes
        set_wb(5'd0, 32'hFFFF);
        set_mdu(5'd0, 32'hEEEE);
        tick();
        idle_in();
        chk("t6_pend_accepted", pend_cnt, 1);
        tick();
        chk("t6_rf_we", rf_we, 0);
        drain("t6");
        chk("t6_rf_we_quiet", rf_we, 0);

        chk("final_exp_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
